// File: rtl/math_pkg.sv
// Shared constants for the 35-bit cascaded multiplier and its streaming wrapper.
package math_pkg;

    localparam int MATH_MULT_35_LAT = 6;
    localparam int MATH_MULT_35_A_W = 42;
    localparam int MATH_MULT_35_B_W = 35;
    localparam int MATH_MULT_35_P_W = 70;

    // operand register + multiplier + scale register
    localparam int MATH_MULT_35_STREAM_STAGES = MATH_MULT_35_LAT + 2;

endpackage

// File: rtl/math_fifo_fwft.sv
// First-word-fall-through FIFO; the writer guarantees it never overflows.
module math_fifo_fwft
    import math_pkg::*;
#(
    parameter int W     = 33,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // extra pointer bit separates full from empty; wrap is free for power-of-two depth
    assign empty   = (wr_ptr == rd_ptr);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/math_mult_35_stream.sv
// Streaming wrapper for math_mult_35: operand handshake, 8-stage tag pipe, scaling, credit FIFO.
// Define MATH_MULT_35_STREAM_ROUND_EN for round-half-up before the shift (truncation otherwise).
module math_mult_35_stream
    import math_pkg::*;
#(
    parameter int SHIFT = 35,
    parameter int OUT_W = 32,
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [34:0]                 in_a,
    input  logic [34:0]                 in_b,
    output logic [MATH_MULT_35_A_W-1:0] mult_dina,
    output logic [MATH_MULT_35_B_W-1:0] mult_dinb,
    input  logic [MATH_MULT_35_P_W-1:0] mult_dout,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_W-1:0]            out_data,
    output logic                        out_sat
);

    localparam int STAGES = MATH_MULT_35_STREAM_STAGES;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]  cnt;
    logic              run;
    logic [STAGES-1:0] vld_p;
    logic [OUT_W:0]    res_p7;
    logic              accept;
    logic              pop;
    logic              fifo_empty;
    logic [OUT_W:0]    fifo_dout;

    // returns {sat, data}
    function automatic logic [OUT_W:0] scale(input logic [MATH_MULT_35_P_W-1:0] p);
        logic [MATH_MULT_35_P_W:0] r;
`ifdef MATH_MULT_35_STREAM_ROUND_EN
        r = ({1'b0, p} + ((MATH_MULT_35_P_W+1)'(1) << (SHIFT - 1))) >> SHIFT;
`else
        r = {1'b0, p} >> SHIFT;
`endif
        if ((r >> OUT_W) != '0) scale = {1'b1, {OUT_W{1'b1}}};
        else                    scale = {1'b0, r[OUT_W-1:0]};
    endfunction

    // run keeps in_ready low until the first edge after reset release
    assign in_ready  = run && (cnt < CNT_W'(DEPTH));
    assign accept    = in_valid && in_ready;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign out_sat   = fifo_dout[OUT_W];
    assign out_data  = fifo_dout[OUT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
            cnt <= '0;
        end else begin
            run <= 1'b1;
            unique case ({accept, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // stage p0: operand register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_dina <= '0;
            mult_dinb <= '0;
        end else if (accept) begin
            mult_dina <= {{(MATH_MULT_35_A_W-35){1'b0}}, in_a};
            mult_dinb <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p <= '0;
        else        vld_p <= {vld_p[STAGES-2:0], accept};
    end

    // stage p7: scale register, loaded as the product leaves the multiplier
    always_ff @(posedge clk) begin
        if (vld_p[STAGES-2]) res_p7 <= scale(mult_dout);
    end

    math_fifo_fwft #(
        .W     (OUT_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (vld_p[STAGES-1]),
        .wr_data (res_p7),
        .rd_en   (pop),
        .rd_data (fifo_dout),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_math_mult_35_stream.sv
// Self-checking bench for math_mult_35_stream with a behavioural 6-cycle multiplier.
module tb_math_mult_35_stream;

    localparam int SHIFT = 35;
    localparam int OUT_W = 32;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [34:0]       in_a;
    logic [34:0]       in_b;
    logic [41:0]       mult_dina;
    logic [34:0]       mult_dinb;
    logic [69:0]       mult_dout;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_sat;

    logic [69:0]      mpipe [6];
    logic [OUT_W:0]   exp_q [$];
    int               errs;
    int               checks;
    int               model_cnt;
    int               max_cnt;
    int               pops;

    math_mult_35_stream #(.SHIFT(SHIFT), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mult_dina (mult_dina),
        .mult_dinb (mult_dinb),
        .mult_dout (mult_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    // stand-in for math_mult_35: 6-cycle product of the registered operands
    assign mult_dout = mpipe[5];
    always @(posedge clk) begin
        mpipe[0] <= 70'(mult_dina) * 70'(mult_dinb);
        for (int i = 1; i < 6; i++) mpipe[i] <= mpipe[i-1];
    end

    function automatic logic [OUT_W:0] ref_res(input logic [34:0] a, input logic [34:0] b);
        logic [127:0] p;
        logic [127:0] r;
        logic [127:0] lim;
        p = 128'(a) * 128'(b);
`ifdef MATH_MULT_35_STREAM_ROUND_EN
        p = p + (128'd1 << (SHIFT - 1));
`endif
        r   = p / (128'd1 << SHIFT);
        lim = (128'd1 << OUT_W) - 128'd1;
        if (r > lim) return {1'b1, {OUT_W{1'b1}}};
        return {1'b0, r[OUT_W-1:0]};
    endfunction

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: score the handshakes that complete at the coming edge
    task automatic tick();
        logic acc;
        logic pp;
        logic [OUT_W:0] e;
        acc = in_valid && in_ready;
        pp  = out_valid && out_ready;
        if (pp) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errs++;
                $error("FAIL unexpected_pop observed=%0h expected=none", {out_sat, out_data});
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pop_data", 70'(out_data), 70'(e[OUT_W-1:0]));
                chk("pop_sat", 70'(out_sat), 70'(e[OUT_W]));
            end
            model_cnt--;
            pops++;
        end
        if (acc) begin
            exp_q.push_back(ref_res(in_a, in_b));
            model_cnt++;
            if (model_cnt > max_cnt) max_cnt = model_cnt;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [34:0] a, input logic [34:0] b,
                            input logic [OUT_W-1:0] ed, input logic es);
        int n;
        in_a = a; in_b = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_a = ~a; in_b = ~b;
        chk({tag, "_dina"}, 70'(mult_dina), 70'({7'b0, a}));
        chk({tag, "_dinb"}, 70'(mult_dinb), 70'(b));
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_dina_hold"}, 70'(mult_dina), 70'({7'b0, a}));
        chk({tag, "_latency"}, 70'(n), 70'(8));
        chk({tag, "_data"}, 70'(out_data), 70'(ed));
        chk({tag, "_sat"}, 70'(out_sat), 70'(es));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_empty_after_pop"}, 70'(out_valid), 70'(0));
    endtask

    initial begin
        int acc_n;
        int n;
        int viol;
        logic [OUT_W-1:0] rnd_exp;
        errs = 0; checks = 0; model_cnt = 0; max_cnt = 0; pops = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        for (int i = 0; i < 6; i++) mpipe[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 70'(in_ready), 70'(0));
        chk("reset_out_valid", 70'(out_valid), 70'(0));
        chk("reset_out_data", 70'(out_data), 70'(0));
        chk("reset_out_sat", 70'(out_sat), 70'(0));
        chk("reset_dina", 70'(mult_dina), 70'(0));
        chk("reset_dinb", 70'(mult_dinb), 70'(0));
        rst_n = 1'b1;
        #1;
        chk("release_ready_before_edge", 70'(in_ready), 70'(0));
        tick();
        chk("release_ready_after_edge", 70'(in_ready), 70'(1));

        directed("scale", 35'd1 << 20, 35'd1 << 20, 32'd32, 1'b0);
`ifdef MATH_MULT_35_STREAM_ROUND_EN
        rnd_exp = 32'd2;
`else
        rnd_exp = 32'd1;
`endif
        directed("round", 35'd3, 35'd1 << 34, rnd_exp, 1'b0);
        directed("sat", {35{1'b1}}, {35{1'b1}}, 32'hFFFF_FFFF, 1'b1);

        // backpressure: 20 pairs offered with out_ready held low
        pops = 0;
        acc_n = 0;
        for (int c = 0; c < 30; c++) begin
            if (acc_n < 20) begin
                in_valid = 1'b1;
                in_a = 35'({$urandom, $urandom}) >> $urandom_range(0, 34);
                in_b = 35'({$urandom, $urandom}) >> $urandom_range(0, 34);
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) acc_n++;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_accepts", 70'(acc_n), 70'(16));
        chk("bp_in_ready_low", 70'(in_ready), 70'(0));
        chk("bp_out_valid", 70'(out_valid), 70'(1));
        out_ready = 1'b1;
        #1;
        chk("full_ready_not_comb", 70'(in_ready), 70'(0));
        tick();
        out_ready = 1'b0;
        chk("full_ready_after_pop", 70'(in_ready), 70'(1));
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        chk("bp_total_popped", 70'(pops), 70'(16));
        chk("bp_drained", 70'(out_valid), 70'(0));

        // reset three cycles after four accepts
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_a = 35'($urandom);
            in_b = 35'($urandom);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        #1;
        chk("mid_rst_out_valid", 70'(out_valid), 70'(0));
        chk("mid_rst_out_data", 70'(out_data), 70'(0));
        chk("mid_rst_out_sat", 70'(out_sat), 70'(0));
        chk("mid_rst_dina", 70'(mult_dina), 70'(0));
        chk("mid_rst_dinb", 70'(mult_dinb), 70'(0));
        chk("mid_rst_in_ready", 70'(in_ready), 70'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("mid_rst_ready_after_release", 70'(in_ready), 70'(1));
        viol = 0;
        repeat (12) begin
            if (out_valid) viol++;
            tick();
        end
        chk("mid_rst_no_stale_valid", 70'(viol), 70'(0));
        directed("post_rst", 35'd24690, 35'd1 << 34, 32'd12345, 1'b0);

        // random traffic with random backpressure
        max_cnt = model_cnt;
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = 35'({$urandom, $urandom}) >> $urandom_range(0, 34);
            in_b      = 35'({$urandom, $urandom}) >> $urandom_range(0, 34);
            out_ready = $urandom_range(0, 1) == 1;
            chk("rand_in_ready", 70'(in_ready), 70'(model_cnt < DEPTH));
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() > 0 || out_valid) && n < 100) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        chk("rand_queue_empty", 70'(exp_q.size()), 70'(0));
        chk("rand_out_idle", 70'(out_valid), 70'(0));
        chk("rand_cnt_within_depth", 70'(max_cnt <= DEPTH), 70'(1));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation bound exceeded");
    end

endmodule
